// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU for the execute stage: operand inversion in S1,
// result and flag computation in S2, valid/ready handshake with full back-pressure.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Ofl,
    output logic             Cout,
    output logic             Z,
    output logic             N
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ofl;
        logic             cout;
    } alu_res_t;

    // Full ALU evaluation on already-inverted operands. SUB shares the adder
    // through b inversion and a forced carry-in of one.
    function automatic alu_res_t alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       op,
        input logic             cin,
        input logic             sgn
    );
        alu_res_t           r;
        logic [SHW-1:0]     n;
        logic [2*WIDTH-1:0] rol_w;
        logic [WIDTH-1:0]   add_b;
        logic               add_c;
        logic               is_sub;
        logic [WIDTH:0]     sum;
        n      = b[SHW-1:0];
        rol_w  = {a, a} << n;
        is_sub = (op == OP_SUB);
        add_b  = is_sub ? ~b : b;
        add_c  = is_sub ? 1'b1 : cin;
        sum    = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};
        r.res  = a;
        r.ofl  = 1'b0;
        r.cout = 1'b0;
        case (op)
            OP_ROL: r.res = rol_w[2*WIDTH-1:WIDTH];
            OP_SLL: r.res = a << n;
            OP_SRA: r.res = $signed(a) >>> n;
            OP_SRL: r.res = a >> n;
            OP_ADD, OP_SUB: begin
                r.res  = sum[WIDTH-1:0];
                r.cout = sum[WIDTH];
                if (sgn) begin
                    r.ofl = (a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end else begin
                    r.ofl = is_sub ? ~sum[WIDTH] : sum[WIDTH];
                end
            end
            OP_XOR: r.res = a ^ b;
            OP_AND: r.res = a & b;
            default: r.res = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [2:0]       s1_op_r;
    logic             s1_cin_r;
    logic             s1_sign_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] out_r;
    logic             ofl_r;
    logic             cout_r;
    logic             z_r;
    logic             n_r;

    logic             s2_en_s;
    logic             in_ready_s;
    alu_res_t         eval_s;

    assign s2_en_s    = !s2_valid_r || out_ready;
    assign in_ready_s = !rst && (!s1_valid_r || s2_en_s);

    // Result of the operation currently held in S1.
    always_comb begin
        eval_s = alu_eval(s1_a_r, s1_b_r, s1_op_r, s1_cin_r, s1_sign_r);
    end

    // Stage 1: capture post-inversion operands and control on an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 3'b000;
            s1_cin_r   <= 1'b0;
            s1_sign_r  <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r    <= invA ? ~A : A;
                s1_b_r    <= invB ? ~B : B;
                s1_op_r   <= Op;
                s1_cin_r  <= Cin;
                s1_sign_r <= sign;
            end
        end
    end

    // Stage 2: result and flag registers; hold while the consumer stalls or S1 is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            out_r      <= {WIDTH{1'b0}};
            ofl_r      <= 1'b0;
            cout_r     <= 1'b0;
            z_r        <= 1'b0;
            n_r        <= 1'b0;
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_r  <= eval_s.res;
                ofl_r  <= eval_s.ofl;
                cout_r <= eval_s.cout;
                z_r    <= (eval_s.res == {WIDTH{1'b0}});
                n_r    <= eval_s.res[WIDTH-1];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign Out       = out_r;
    assign Ofl       = ofl_r;
    assign Cout      = cout_r;
    assign Z         = z_r;
    assign N         = n_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: WIDTH=16 and WIDTH=32 instances checked
// against an arithmetic reference model and a FIFO scoreboard.
module tb_alu_pipe;

    localparam logic [2:0] OP_ROL = 3'd0;
    localparam logic [2:0] OP_SLL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_AND = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        ia;
        logic        ib;
        logic        sg;
        logic [31:0] out;
        logic        ofl;
        logic        cout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        cin, inva, invb, sign;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] out16;
    logic        ofl16, cout16, z16, n16;
    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] out32;
    logic        ofl32, cout32, z32, n32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(a_in[15:0]), .B(b_in[15:0]), .Cin(cin), .Op(op), .invA(inva), .invB(invb),
        .sign(sign), .out_valid(out_valid16), .out_ready(out_ready16), .Out(out16),
        .Ofl(ofl16), .Cout(cout16), .Z(z16), .N(n16)
    );

    alu_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .A(a_in), .B(b_in), .Cin(cin), .Op(op), .invA(inva), .invB(invb),
        .sign(sign), .out_valid(out_valid32), .out_ready(out_ready32), .Out(out32),
        .Ofl(ofl32), .Cout(cout32), .Z(z32), .N(n32)
    );

    // Reference model: returns {ofl, cout, result[63:0]} using plain integer arithmetic.
    function automatic logic [65:0] model(input int w, input logic [2:0] o, input logic [63:0] ar,
                                          input logic [63:0] br, input logic c, input logic ia,
                                          input logic ib, input logic sg);
        logic [63:0] mask, a, b, res, sum;
        logic        co, ov;
        int          n;
        longint      sa, sb, st, lim;
        mask = (64'd1 << w) - 64'd1;
        a    = (ia ? ~ar : ar) & mask;
        b    = (ib ? ~br : br) & mask;
        n    = int'(b % 64'(w));
        res  = 64'd0;
        co   = 1'b0;
        ov   = 1'b0;
        sa   = longint'(a);
        sb   = longint'(b);
        if (a[w-1]) sa = sa - longint'(64'd1 << w);
        if (b[w-1]) sb = sb - longint'(64'd1 << w);
        lim  = longint'(64'd1 << (w - 1));
        case (o)
            OP_ROL: for (int i = 0; i < w; i++) if (a[i]) res[(i + n) % w] = 1'b1;
            OP_SLL: res = (a << n) & mask;
            OP_SRA: for (int i = 0; i < w; i++) res[i] = (i + n < w) ? a[i + n] : a[w-1];
            OP_SRL: res = a >> n;
            OP_ADD: begin
                sum = a + b + 64'(c);
                res = sum & mask;
                co  = sum[w];
                st  = sa + sb + longint'(c);
                ov  = sg ? (st >= lim || st < -lim) : co;
            end
            OP_SUB: begin
                res = (a - b) & mask;
                co  = (a >= b);
                st  = sa - sb;
                ov  = sg ? (st >= lim || st < -lim) : !co;
            end
            OP_XOR: res = a ^ b;
            default: res = a & b;
        endcase
        return {ov, co, res};
    endfunction

    // Expected {Ofl, Cout, Z, N} for a given result.
    function automatic logic [3:0] exp_flags(input int w, input logic [31:0] o,
                                             input logic ofl, input logic cout);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return {ofl, cout, ((64'(o) & mask) == 64'd0), o[w-1]};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.op   = 3'($urandom_range(0, 7));
        v.a    = $urandom;
        v.b    = $urandom;
        v.cin  = 1'($urandom_range(0, 1));
        v.ia   = 1'($urandom_range(0, 1));
        v.ib   = 1'($urandom_range(0, 1));
        v.sg   = 1'($urandom_range(0, 1));
        v.out  = 32'd0;
        v.ofl  = 1'b0;
        v.cout = 1'b0;
        return v;
    endfunction

    task automatic drive_vec(input vec_t v);
        op   = v.op;
        a_in = v.a;
        b_in = v.b;
        cin  = v.cin;
        inva = v.ia;
        invb = v.ib;
        sign = v.sg;
    endtask

    // Send one operation to the chosen instance and wait for its result; lat counts
    // edges from the accepting edge (1) to the edge after which out_valid is seen.
    task automatic do_op(input bit w32, input vec_t v, output logic [31:0] res,
                         output logic [3:0] fl, output int lat);
        int t = 0;
        drive_vec(v);
        if (w32) begin in_valid32 = 1'b1; out_ready32 = 1'b1; end
        else begin in_valid16 = 1'b1; out_ready16 = 1'b1; end
        #1;
        while (!(w32 ? in_ready32 : in_ready16) && t < 20) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        in_valid32 = 1'b0;
        lat = 1;
        while (!(w32 ? out_valid32 : out_valid16) && lat < 10) begin @(posedge clk); #1; lat++; end
        if (lat >= 10) begin
            checks++; errors++;
            $display("FAIL op_timeout w32=%0d op=%0d no out_valid within 10 edges", w32, v.op);
        end
        res = w32 ? out32 : {16'h0000, out16};
        fl  = w32 ? {ofl32, cout32, z32, n32} : {ofl16, cout16, z16, n16};
    endtask

    task automatic test_reset();
        vec_t v; logic [31:0] res; logic [3:0] fl; int lat;
        rst = 1'b1; in_valid16 = 1'b1; in_valid32 = 1'b1; out_ready16 = 1'b1; out_ready32 = 1'b1;
        op = OP_ADD; a_in = 32'h1111_1111; b_in = 32'h2222_2222; cin = 1'b0;
        inva = 1'b0; invb = 1'b0; sign = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({in_ready16, out_valid16, out16, ofl16, cout16, z16, n16} !== 22'd0) begin
                errors++;
                $display("FAIL reset16 cyc%0d rdy=%b vld=%b out=%h flags=%b%b%b%b want all 0",
                         i, in_ready16, out_valid16, out16, ofl16, cout16, z16, n16);
            end
            checks++;
            if ({in_ready32, out_valid32, out32, ofl32, cout32, z32, n32} !== 38'd0) begin
                errors++;
                $display("FAIL reset32 cyc%0d rdy=%b vld=%b out=%h want all 0",
                         i, in_ready32, out_valid32, out32);
            end
        end
        rst = 1'b0; in_valid16 = 1'b0; in_valid32 = 1'b0;
        v = '{OP_ADD, 32'h1234, 32'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1235, 1'b0, 1'b0};
        do_op(1'b0, v, res, fl, lat);
        checks++;
        if (lat !== 2 || res[15:0] !== 16'h1235) begin
            errors++;
            $display("FAIL first_after_reset lat=%0d out=%h want lat=2 out=1235", lat, res[15:0]);
        end
    endtask

    task automatic test_arith();
        vec_t t[4]; logic [31:0] res; logic [3:0] fl; int lat;
        t[0] = '{OP_ADD, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000, 1'b1, 1'b0};
        t[1] = '{OP_ADD, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b1};
        t[2] = '{OP_SUB, 32'h0003, 32'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFE, 1'b1, 1'b0};
        t[3] = '{OP_SUB, 32'h0005, 32'h0005, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, t[i], res, fl, lat);
            checks++;
            if ({res[15:0], fl} !== {t[i].out[15:0], exp_flags(16, t[i].out, t[i].ofl, t[i].cout)}) begin
                errors++;
                $display("FAIL arith[%0d] out=%h ofl,cout,z,n=%b want out=%h flags=%b", i, res[15:0], fl,
                         t[i].out[15:0], exp_flags(16, t[i].out, t[i].ofl, t[i].cout));
            end
        end
    endtask

    task automatic test_shift();
        vec_t t[5]; logic [31:0] res; logic [3:0] fl; int lat;
        t[0] = '{OP_ROL, 32'h8001, 32'h0004, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0018, 1'b0, 1'b0};
        t[1] = '{OP_ROL, 32'h8001, 32'h0014, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0018, 1'b0, 1'b0};
        t[2] = '{OP_SRA, 32'h8000, 32'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF000, 1'b0, 1'b0};
        t[3] = '{OP_SRL, 32'h8000, 32'h0003, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000, 1'b0, 1'b0};
        t[4] = '{OP_SLL, 32'h0001, 32'h000F, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, t[i], res, fl, lat);
            checks++;
            if ({res[15:0], fl} !== {t[i].out[15:0], exp_flags(16, t[i].out, 1'b0, 1'b0)}) begin
                errors++;
                $display("FAIL shift[%0d] out=%h flags=%b want out=%h flags=%b", i, res[15:0], fl,
                         t[i].out[15:0], exp_flags(16, t[i].out, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_invert();
        vec_t t[2]; logic [31:0] res; logic [3:0] fl; int lat;
        t[0] = '{OP_AND, 32'h00FF, 32'h0F0F, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0F00, 1'b0, 1'b0};
        t[1] = '{OP_ADD, 32'h0000, 32'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            do_op(1'b0, t[i], res, fl, lat);
            checks++;
            if ({res[15:0], fl} !== {t[i].out[15:0], exp_flags(16, t[i].out, t[i].ofl, t[i].cout)}) begin
                errors++;
                $display("FAIL invert[%0d] out=%h flags=%b want out=%h flags=%b", i, res[15:0], fl,
                         t[i].out[15:0], exp_flags(16, t[i].out, t[i].ofl, t[i].cout));
            end
        end
    endtask

    task automatic test_width32();
        vec_t t[2]; logic [31:0] res; logic [3:0] fl; int lat;
        t[0] = '{OP_ROL, 32'h8000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
        t[1] = '{OP_SRA, 32'h8000_0000, 32'h0000_001F, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            do_op(1'b1, t[i], res, fl, lat);
            checks++;
            if ({res, fl} !== {t[i].out, exp_flags(32, t[i].out, 1'b0, 1'b0)}) begin
                errors++;
                $display("FAIL width32[%0d] out=%h flags=%b want out=%h flags=%b", i, res, fl,
                         t[i].out, exp_flags(32, t[i].out, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_random_ops();
        vec_t v; logic [31:0] res; logic [3:0] fl, ef; int lat, w; logic [65:0] m; bit bad;
        for (int i = 0; i < 60; i++) begin
            v  = rand_vec();
            w  = (i % 2 == 1) ? 32 : 16;
            m  = model(w, v.op, 64'(v.a), 64'(v.b), v.cin, v.ia, v.ib, v.sg);
            ef = exp_flags(w, m[31:0], m[65], m[64]);
            do_op(w == 32, v, res, fl, lat);
            bad = (w == 32) ? ({res, fl} !== {m[31:0], ef}) : ({res[15:0], fl} !== {m[15:0], ef});
            checks++;
            if (bad || lat !== 2) begin
                errors++;
                $display("FAIL random_op[%0d] w=%0d op=%0d out=%h flags=%b lat=%0d want out=%h flags=%b lat=2",
                         i, w, v.op, res, fl, lat, m[31:0], ef);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] q[$]; logic [19:0] e; vec_t v[6]; logic [65:0] m;
        int sent = 0, got = 0, cyc = 0, stall = 0; bit prev_hold = 1'b0, saw_block = 1'b0;
        logic [15:0] held = 16'h0;
        for (int i = 0; i < 6; i++) v[i] = rand_vec();
        while (got < 6 && cyc < 100) begin
            if (stall < 4 && (stall > 0 || out_valid16)) begin out_ready16 = 1'b0; stall++; end
            else out_ready16 = 1'b1;
            if (sent < 6) begin drive_vec(v[sent]); in_valid16 = 1'b1; end
            else in_valid16 = 1'b0;
            #1;
            checks++;
            if (in_ready16 !== ((q.size() < 2) || out_ready16)) begin
                errors++;
                $display("FAIL b2b_ready cyc%0d in_ready=%b held=%0d out_ready=%b", cyc, in_ready16, q.size(), out_ready16);
            end
            if (!in_ready16) saw_block = 1'b1;
            if (prev_hold) begin
                checks++;
                if (out_valid16 !== 1'b1 || out16 !== held) begin
                    errors++;
                    $display("FAIL b2b_stable cyc%0d vld=%b out=%h want vld=1 out=%h", cyc, out_valid16, out16, held);
                end
            end
            if (out_valid16 && out_ready16) begin
                checks++;
                e = (q.size() > 0) ? q.pop_front() : 20'hxxxxx;
                if ({ofl16, cout16, z16, n16, out16} !== e) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got=%h want=%h", got, {ofl16, cout16, z16, n16, out16}, e);
                end
                got++;
            end
            if (in_valid16 && in_ready16) begin
                m = model(16, v[sent].op, 64'(v[sent].a), 64'(v[sent].b), v[sent].cin, v[sent].ia, v[sent].ib, v[sent].sg);
                q.push_back({exp_flags(16, m[31:0], m[65], m[64]), m[15:0]});
                sent++;
            end
            prev_hold = out_valid16 && !out_ready16;
            held = out16;
            @(posedge clk); #1; cyc++;
        end
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        checks++;
        if (got != 6 || !saw_block) begin
            errors++;
            $display("FAIL b2b_count got=%0d blocked=%b want 6 results and in_ready low during stall", got, saw_block);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (out_valid16 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_extra out_valid=%b after all results retired, want 0", out_valid16);
        end
    endtask

    task automatic test_random_backpressure();
        logic [19:0] q[$]; logic [19:0] e; vec_t v; logic [65:0] m;
        int sent = 0, got = 0, cyc = 0; bit prev_hold = 1'b0; logic [15:0] held = 16'h0;
        v = rand_vec();
        while (got < 2000 && cyc < 30000) begin
            out_ready16 = ($urandom_range(0, 9) < 6);
            in_valid16  = (sent < 2000) && ($urandom_range(0, 3) != 0);
            drive_vec(v);
            #1;
            checks++;
            if (in_ready16 !== ((q.size() < 2) || out_ready16)) begin
                errors++;
                $display("FAIL bp_ready cyc%0d in_ready=%b held=%0d out_ready=%b", cyc, in_ready16, q.size(), out_ready16);
            end
            if (prev_hold) begin
                checks++;
                if (out_valid16 !== 1'b1 || out16 !== held) begin
                    errors++;
                    $display("FAIL bp_stable cyc%0d vld=%b out=%h want vld=1 out=%h", cyc, out_valid16, out16, held);
                end
            end
            if (out_valid16 && out_ready16) begin
                checks++;
                e = (q.size() > 0) ? q.pop_front() : 20'hxxxxx;
                if ({ofl16, cout16, z16, n16, out16} !== e) begin
                    errors++;
                    $display("FAIL bp_result[%0d] got=%h want=%h", got, {ofl16, cout16, z16, n16, out16}, e);
                end
                got++;
            end
            if (in_valid16 && in_ready16) begin
                m = model(16, v.op, 64'(v.a), 64'(v.b), v.cin, v.ia, v.ib, v.sg);
                q.push_back({exp_flags(16, m[31:0], m[65], m[64]), m[15:0]});
                sent++;
                v = rand_vec();
            end
            prev_hold = out_valid16 && !out_ready16;
            held = out16;
            @(posedge clk); #1; cyc++;
        end
        in_valid16 = 1'b0; out_ready16 = 1'b1;
        checks++;
        if (got != 2000 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count got=%0d pending=%0d want 2000 and 0", got, q.size());
        end
    endtask

    task automatic test_flush32();
        bit seen = 1'b0;
        out_ready32 = 1'b0;
        in_valid32  = 1'b1;
        op = OP_XOR; a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678; inva = 1'b0; invb = 1'b0;
        @(posedge clk); #1;
        a_in = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        in_valid32 = 1'b0;
        checks++;
        if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0) begin
            errors++;
            $display("FAIL flush_setup vld=%b rdy=%b want vld=1 rdy=0 (two ops held)", out_valid32, in_ready32);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready32 = 1'b1;
        checks++;
        if ({out_valid32, out32} !== 33'd0) begin
            errors++;
            $display("FAIL flush_clear vld=%b out=%h want 0", out_valid32, out32);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid32) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_emerged out_valid seen=%b after reset, want 0", seen);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid16 = 1'b0; in_valid32 = 1'b0; out_ready16 = 1'b1; out_ready32 = 1'b1;
        op = 3'd0; a_in = 32'd0; b_in = 32'd0; cin = 1'b0; inva = 1'b0; invb = 1'b0; sign = 1'b0;
        test_reset();
        test_arith();
        test_shift();
        test_invert();
        test_width32();
        test_random_ops();
        test_back_to_back();
        test_random_backpressure();
        test_flush32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
